// File: rtl/simon_round_sequencer.sv
// simon_round_sequencer: Simon game core. Grows a random 2-bit colour
// sequence by one step per round, plays it back on the LEDs with timed
// on/off gaps, checks the player's presses and ends in WIN or LOSE.
// All outputs come straight from flops that are loaded together with the
// state register, so every output reflects the state entered on that edge.
module simon_round_sequencer #(
    parameter int         MAX_LEN       = 8,
    parameter int         ON_TICKS      = 4,
    parameter int         OFF_TICKS     = 2,
    parameter int         TIMEOUT_TICKS = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] buttons,
    output logic [3:0] leds,
    output logic [3:0] round,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    // Last timer value before each timed phase ends (timer counts from zero).
    localparam logic [15:0] ON_LAST      = 16'(ON_TICKS - 1);
    localparam logic [15:0] OFF_LAST     = 16'(OFF_TICKS - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]  MAX_LEN_L    = 4'(MAX_LEN);

    // Colour index to one-hot LED pattern.
    function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
        return 4'b0001 << colour;
    endfunction

    // Next value of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR (shift left).
    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  leds_q, leds_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        busy_q, busy_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;

    // Pattern memory is addressed by the full 4-bit index; only the first
    // MAX_LEN entries are ever written or read. It is never reset.
    logic [1:0]  mem_q [16];
    logic        mem_we;

    logic        press;
    logic        last_idx;
    logic [3:0]  expected;
    logic [1:0]  first_colour;
    logic [1:0]  next_colour;

    // Shared decode: press detection, expected colour and playback lookups.
    always_comb begin
        press    = (buttons != 4'b0000);
        last_idx = (idx_q == (len_q - 4'd1));
        expected = colour_onehot(mem_q[idx_q]);
        // In round 1 the entry being written this cycle is the one shown first.
        if (len_q == 4'd0) begin
            first_colour = lfsr_q[1:0];
        end else begin
            first_colour = mem_q[4'd0];
        end
        next_colour = mem_q[idx_q + 4'd1];
    end

    // Next-state, index, timer and LED computation for the game FSM.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        leds_d  = leds_q;
        lfsr_d  = lfsr_step(lfsr_q);
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                leds_d = 4'b0000;
                if (start) begin
                    state_d = S_GEN;
                    len_d   = 4'd0;
                    timer_d = 16'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GEN: begin
                mem_we  = 1'b1;
                len_d   = len_q + 4'd1;
                idx_d   = 4'd0;
                timer_d = 16'd0;
                state_d = S_SHOW_ON;
                leds_d  = colour_onehot(first_colour);
            end

            S_SHOW_ON: begin
                if (tick) begin
                    if (timer_q == ON_LAST) begin
                        state_d = S_SHOW_OFF;
                        timer_d = 16'd0;
                        leds_d  = 4'b0000;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end

            S_SHOW_OFF: begin
                leds_d = 4'b0000;
                if (tick) begin
                    if (timer_q == OFF_LAST) begin
                        timer_d = 16'd0;
                        if (last_idx) begin
                            state_d = S_INPUT;
                            idx_d   = 4'd0;
                        end else begin
                            state_d = S_SHOW_ON;
                            idx_d   = idx_q + 4'd1;
                            leds_d  = colour_onehot(next_colour);
                        end
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end

            S_INPUT: begin
                // A press beats a tick in the same cycle and restarts the timeout.
                if (press) begin
                    timer_d = 16'd0;
                    if (buttons == expected) begin
                        if (last_idx) begin
                            if (len_q == MAX_LEN_L) begin
                                state_d = S_WIN;
                                leds_d  = 4'b1111;
                            end else begin
                                state_d = S_GEN;
                                leds_d  = 4'b0000;
                            end
                        end else begin
                            idx_d  = idx_q + 4'd1;
                            leds_d = buttons;
                        end
                    end else begin
                        state_d = S_LOSE;
                        leds_d  = 4'b1111;
                    end
                end else if (tick) begin
                    if (timer_q == TIMEOUT_LAST) begin
                        state_d = S_LOSE;
                        timer_d = 16'd0;
                        leds_d  = 4'b1111;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end

            S_WIN: begin
                if (start) begin
                    state_d = S_GEN;
                    len_d   = 4'd0;
                    timer_d = 16'd0;
                    leds_d  = 4'b0000;
                end else begin
                    leds_d = 4'b1111;
                end
            end

            S_LOSE: begin
                if (start) begin
                    state_d = S_GEN;
                    len_d   = 4'd0;
                    timer_d = 16'd0;
                    leds_d  = 4'b0000;
                end else if (tick) begin
                    leds_d = ~leds_q;
                end else begin
                    leds_d = leds_q;
                end
            end

            default: begin
                state_d = S_IDLE;
                len_d   = 4'd0;
                idx_d   = 4'd0;
                timer_d = 16'd0;
                leds_d  = 4'b0000;
            end
        endcase

        busy_d = (state_d == S_GEN) || (state_d == S_SHOW_ON) ||
                 (state_d == S_SHOW_OFF) || (state_d == S_INPUT);
        win_d  = (state_d == S_WIN);
        lose_d = (state_d == S_LOSE);
    end

    // State, indices, timer, LFSR and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= 4'd0;
            idx_q   <= 4'd0;
            timer_q <= 16'd0;
            leds_q  <= 4'b0000;
            lfsr_q  <= LFSR_SEED;
            busy_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            leds_q  <= leds_d;
            lfsr_q  <= lfsr_d;
            busy_q  <= busy_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    // Pattern memory write: one new colour appended per GEN cycle.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[len_q] <= lfsr_q[1:0];
        end
    end

    assign leds  = leds_q;
    assign round = len_q;
    assign busy  = busy_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: tb/tb_simon_round_sequencer.sv
// tb_simon_round_sequencer: directed game flows with randomized timing and
// button noise, checked against a reference that tracks the LFSR and the
// expected colour sequence. Two instances: the default game and a
// single-round game with one-tick on/off phases.
module tb_simon_round_sequencer;

    localparam logic [7:0] SEED = 8'hA5;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       tick    = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] buttons = 4'd0;

    logic [3:0] leds_a, round_a, leds_b, round_b;
    logic       busy_a, win_a, lose_a, busy_b, win_b, lose_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_lfsr;
    logic [1:0] pat[$];

    simon_round_sequencer #(
        .MAX_LEN(8), .ON_TICKS(4), .OFF_TICKS(2), .TIMEOUT_TICKS(16), .LFSR_SEED(SEED)
    ) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .buttons(buttons),
        .leds(leds_a), .round(round_a), .busy(busy_a), .win(win_a), .lose(lose_a)
    );

    simon_round_sequencer #(
        .MAX_LEN(1), .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(16), .LFSR_SEED(SEED)
    ) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .buttons(buttons),
        .leds(leds_b), .round(round_b), .busy(busy_b), .win(win_b), .lose(lose_b)
    );

    always #5 clk = ~clk;

    // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, advances every clock.
    function automatic logic [7:0] ref_lfsr_next(input logic [7:0] v);
        logic fb;
        fb = 1'b0;
        foreach (v[b]) begin
            if (b == 7 || b == 5 || b == 4 || b == 3) fb = fb ^ v[b];
        end
        return {v[6:0], fb};
    endfunction

    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= ref_lfsr_next(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_leds(input int d, input string tag, input logic [3:0] e);
        chk({tag, "/leds"}, (d == 0) ? leds_a : leds_b, e);
    endtask

    task automatic chk_all(input int d, input string tag, input logic [3:0] e_leds,
                           input logic e_busy, input logic e_win, input logic e_lose,
                           input logic [3:0] e_round);
        chk_leds(d, tag, e_leds);
        chk({tag, "/busy"},  (d == 0) ? busy_a  : busy_b,  e_busy);
        chk({tag, "/win"},   (d == 0) ? win_a   : win_b,   e_win);
        chk({tag, "/lose"},  (d == 0) ? lose_a  : lose_b,  e_lose);
        chk({tag, "/round"}, (d == 0) ? round_a : round_b, e_round);
    endtask

    // One clock: inputs set beforehand are sampled, pulses then dropped.
    task automatic cyc();
        @(posedge clk);
        #1;
        start   = 1'b0;
        buttons = 4'd0;
        tick    = 1'b0;
    endtask

    task automatic reset_all();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk_all(0, "reset_a", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk_all(1, "reset_b", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Idle cycles with LEDs expected steady; noise drives ignored presses/starts.
    task automatic idle(input int d, input int n, input logic [3:0] e_leds, input bit noise);
        for (int k = 0; k < n; k++) begin
            if (noise) begin
                buttons = 4'($urandom_range(1, 15));
                start   = 1'b1;
            end
            cyc();
            chk_leds(d, "hold", e_leds);
        end
    endtask

    // Start a new game; the cycle after start is GEN and captures the colour.
    task automatic start_game(input int d);
        pat.delete();
        start = 1'b1;
        cyc();
        chk_all(d, "gen_first", 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        pat.push_back(m_lfsr[1:0]);
    endtask

    // In GEN after a completed round: capture the next colour.
    task automatic next_gen(input int d, input int prev_len);
        chk_all(d, "gen_next", 4'd0, 1'b1, 1'b0, 1'b0, 4'(prev_len));
        pat.push_back(m_lfsr[1:0]);
    endtask

    // From GEN: check the whole playback, ending in INPUT.
    task automatic playback(input int d, input int on_t, input int off_t, input bit noise);
        cyc();
        for (int i = 0; i < pat.size(); i++) begin
            logic [3:0] on_l;
            on_l = 4'b0001 << pat[i];
            chk_all(d, "show_on", on_l, 1'b1, 1'b0, 1'b0, 4'(pat.size()));
            for (int t = 0; t < on_t; t++) begin
                idle(d, $urandom_range(0, 2), on_l, noise);
                tick = 1'b1;
                cyc();
                if (t < on_t - 1) chk_leds(d, "on_tick", on_l);
                else              chk_leds(d, "on_end", 4'd0);
            end
            for (int t = 0; t < off_t; t++) begin
                idle(d, $urandom_range(0, 2), 4'd0, noise);
                tick = 1'b1;
                cyc();
                if (t < off_t - 1) chk_leds(d, "off_tick", 4'd0);
            end
        end
        chk_all(d, "input_entry", 4'd0, 1'b1, 1'b0, 1'b0, 4'(pat.size()));
    endtask

    // Enter the whole sequence correctly; final outcome checked by caller.
    task automatic answer(input int d);
        logic [3:0] shown;
        shown = 4'd0;
        for (int i = 0; i < pat.size(); i++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int k = 0; k < gap; k++) begin
                tick = ($urandom_range(0, 2) == 0);
                cyc();
                chk_leds(d, "input_hold", shown);
            end
            buttons = 4'b0001 << pat[i];
            tick    = $urandom_range(0, 1) == 1;
            cyc();
            shown = 4'b0001 << pat[i];
            if (i < pat.size() - 1)
                chk_all(d, "press_ok", shown, 1'b1, 1'b0, 1'b0, 4'(pat.size()));
        end
    endtask

    initial begin
        logic [1:0] wrong;

        reset_all();

        // Single-round instance: play, press correctly, win.
        start_game(1);
        playback(1, 1, 1, 1'b0);
        buttons = 4'b0001 << pat[0];
        cyc();
        chk_all(1, "b_win", 4'b1111, 1'b0, 1'b1, 1'b0, 4'd1);

        // Single-round instance: wrong colour loses, LEDs toggle per tick.
        reset_all();
        start_game(1);
        playback(1, 1, 1, 1'b0);
        wrong   = pat[0] + 2'd1;
        buttons = 4'b0001 << wrong;
        cyc();
        chk_all(1, "b_lose", 4'b1111, 1'b0, 1'b0, 1'b1, 4'd1);
        tick = 1'b1;
        cyc();
        chk_leds(1, "lose_tog1", 4'b0000);
        idle(1, 2, 4'b0000, 1'b0);
        tick = 1'b1;
        cyc();
        chk_leds(1, "lose_tog2", 4'b1111);
        start = 1'b1;
        cyc();
        chk_all(1, "restart_from_lose", 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Timeout: 15 ticks keep waiting, the 16th loses.
        reset_all();
        start_game(0);
        playback(0, 4, 2, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            idle(0, $urandom_range(0, 1), 4'd0, 1'b0);
            tick = 1'b1;
            cyc();
            chk(string'("timeout_wait"), lose_a, 1'b0);
        end
        tick = 1'b1;
        cyc();
        chk_all(0, "timeout_lose", 4'b1111, 1'b0, 1'b0, 1'b1, 4'd1);

        // A press coinciding with the 15th tick restarts the count.
        reset_all();
        start_game(0);
        playback(0, 4, 2, 1'b0);
        answer(0);
        next_gen(0, 1);
        playback(0, 4, 2, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            tick = 1'b1;
            cyc();
        end
        tick    = 1'b1;
        buttons = 4'b0001 << pat[0];
        cyc();
        chk_all(0, "press_on_tick", 4'b0001 << pat[0], 1'b1, 1'b0, 1'b0, 4'd2);
        for (int k = 1; k <= 15; k++) begin
            tick = 1'b1;
            cyc();
            chk(string'("restart_wait"), lose_a, 1'b0);
        end
        tick = 1'b1;
        cyc();
        chk_all(0, "restart_lose", 4'b1111, 1'b0, 1'b0, 1'b1, 4'd2);

        // Noise during playback is ignored; multi-hot press loses.
        reset_all();
        start_game(0);
        playback(0, 4, 2, 1'b1);
        buttons = 4'b0011;
        cyc();
        chk_all(0, "multi_hot", 4'b1111, 1'b0, 1'b0, 1'b1, 4'd1);

        // Full eight-round game with noisy playback in round 2.
        reset_all();
        start_game(0);
        for (int r = 1; r <= 8; r++) begin
            playback(0, 4, 2, r == 2);
            answer(0);
            if (r < 8) next_gen(0, r);
        end
        chk_all(0, "full_win", 4'b1111, 1'b0, 1'b1, 1'b0, 4'd8);
        idle(0, 3, 4'b1111, 1'b0);

        // Reset during round-3 playback, then a fresh game.
        reset_all();
        start_game(0);
        playback(0, 4, 2, 1'b0);
        answer(0);
        next_gen(0, 1);
        playback(0, 4, 2, 1'b0);
        answer(0);
        next_gen(0, 2);
        cyc();
        chk_all(0, "r3_show", 4'b0001 << pat[0], 1'b1, 1'b0, 1'b0, 4'd3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_all(0, "mid_reset", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        start_game(0);
        playback(0, 4, 2, 1'b0);
        answer(0);
        next_gen(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
